// File: rtl/reg_writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types for the register write-back arbiter: data/index widths, the
// per-cycle grant encoding and the load-buffer entry layout.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_ALU  = 2'd1,
        GNT_LD   = 2'd2
    } wb_gnt_e;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// reg_writeback_arbiter_if
// Bundles the ALU result handshake, the load-return handshake and the register
// bank write port of the write-back arbiter.
//   alu_valid/alu_ready/alu_dest/alu_data : ALU result channel
//   ld_valid/ld_ready/ld_dest/ld_data     : load-return channel
//   wr_en/wr_dest/wr_data                 : register bank write port
//   busy_mask                             : registers with a buffered load pending
// Modports: slave  = arbiter side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface reg_writeback_arbiter_if;
    import wb_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_dest;
    logic [DATA_W-1:0] ld_data;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_dest;
    logic [DATA_W-1:0] wr_data;

    logic [NUM_REGS-1:0] busy_mask;

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  ld_valid, ld_dest, ld_data,
        output alu_ready, ld_ready,
        output wr_en, wr_dest, wr_data,
        output busy_mask
    );

    modport master (
        output alu_valid, alu_dest, alu_data,
        output ld_valid, ld_dest, ld_data,
        input  alu_ready, ld_ready,
        input  wr_en, wr_dest, wr_data,
        input  busy_mask
    );

endinterface

// File: rtl/reg_writeback_arbiter_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Load-return buffer for the write-back arbiter. Strict FIFO order, pointers
// wrap modulo FIFO_DEPTH (power of 2, >= 2). Push while full and pop while
// empty are ignored.
// Optional feature macro: WB_PENDING_MASK_EN -- when defined, o_busy_mask is a
// registered bitmap of destinations held in valid entries; otherwise it is 0
// and no per-entry compare logic exists.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_push       : write i_entry at the tail
//   i_pop        : drop the head entry
//   i_entry      : entry to push
//   o_head       : current head entry
//   o_full       : FIFO_DEPTH entries held
//   o_empty      : no entries held
//   o_busy_mask  : pending-destination bitmap
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic                i_pop,
    input  wb_entry_t           i_entry,
    output wb_entry_t           o_head,
    output logic                o_full,
    output logic                o_empty,
    output logic [NUM_REGS-1:0] o_busy_mask
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
    end

`ifdef WB_PENDING_MASK_EN
    logic [NUM_REGS-1:0] w_mask;
    logic [NUM_REGS-1:0] r_busy_mask;

    // Slot i is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] w_off;
        w_mask = '0;
        w_off  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            w_off = PTR_W'(i) - r_rd_ptr;
            if ({1'b0, w_off} < r_count) begin
                w_mask[r_mem[i].dest] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy_mask <= '0;
        else        r_busy_mask <= w_mask;
    end

    assign o_busy_mask = r_busy_mask;
`else
    assign o_busy_mask = '0;
`endif

endmodule

// File: rtl/reg_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// reg_writeback_arbiter
// Single writer for the register bank write port. Merges ALU results and
// buffered load-return data into one registered write per cycle. ALU has
// priority; after STARVE_MAX consecutive ALU grants with loads waiting, one
// load grant is forced and the ALU is stalled for that cycle.
// Data/index widths (DATA_W, ADDR_W) come from wb_pkg.
// Optional feature macro: WB_PENDING_MASK_EN (drives busy_mask, see wb_fifo).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : reg_writeback_arbiter_if.slave (ALU channel, load channel,
//            register bank write port, busy_mask)
// -----------------------------------------------------------------------------
module reg_writeback_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_writeback_arbiter_if.slave bus
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    wb_gnt_e           w_gnt;
    logic              w_force;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    wb_entry_t         w_ld_entry;
    wb_entry_t         w_head;

    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_dest;
    logic [DATA_W-1:0] r_wr_data;

    assign w_ld_entry.dest = bus.ld_dest;
    assign w_ld_entry.data = bus.ld_data;

    // ld_ready comes from the registered count only, so a pop in the same
    // cycle never opens a slot for a push.
    assign w_push = bus.ld_valid && !w_full;
    assign w_pop  = (w_gnt == GNT_LD);

    wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_entry     (w_ld_entry),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_busy_mask (bus.busy_mask)
    );

    assign w_force = (r_starve_cnt == SC_W'(STARVE_MAX)) && !w_empty;

    always_comb begin
        w_gnt = GNT_NONE;
        if (w_force)            w_gnt = GNT_LD;
        else if (bus.alu_valid) w_gnt = GNT_ALU;
        else if (!w_empty)      w_gnt = GNT_LD;
    end

    // Counts ALU grants that bypassed a waiting load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_empty || (w_gnt == GNT_LD)) begin
            r_starve_cnt <= '0;
        end else if ((w_gnt == GNT_ALU) && (r_starve_cnt != SC_W'(STARVE_MAX))) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_dest <= '0;
            r_wr_data <= '0;
        end else begin
            case (w_gnt)
                GNT_ALU: begin
                    r_wr_en   <= 1'b1;
                    r_wr_dest <= bus.alu_dest;
                    r_wr_data <= bus.alu_data;
                end
                GNT_LD: begin
                    r_wr_en   <= 1'b1;
                    r_wr_dest <= w_head.dest;
                    r_wr_data <= w_head.data;
                end
                default: begin
                    r_wr_en   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_ready = !w_force;
    assign bus.ld_ready  = !w_full;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_dest   = r_wr_dest;
    assign bus.wr_data   = r_wr_data;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    reg_writeback_arbiter_if bus ();

    reg_writeback_arbiter #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [3:0] dest,
                            input logic [31:0] data);
        check({tag, "_en"},   32'(bus.wr_en),   32'(en));
        check({tag, "_dest"}, 32'(bus.wr_dest), 32'(dest));
        check({tag, "_data"}, bus.wr_data,      data);
    endtask

    logic [15:0] mask_e2;
    logic [15:0] mask_e3;
    logic [15:0] mask_e5;

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_dest  = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_dest   = '0;
        bus.ld_data   = '0;
`ifdef WB_PENDING_MASK_EN
        mask_e2 = 16'h0080;
        mask_e3 = 16'h0280;
        mask_e5 = 16'h0200;
`else
        mask_e2 = 16'h0000;
        mask_e3 = 16'h0000;
        mask_e5 = 16'h0000;
`endif

        // Reset state
        tick();
        tick();
        check_wr("rst", 1'b0, 4'd0, 32'h0);
        rst_n = 1'b1;
        tick();
        check_wr("post_rst", 1'b0, 4'd0, 32'h0);
        check("post_rst_ld_ready",  32'(bus.ld_ready),  32'd1);
        check("post_rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        check("post_rst_mask",      32'(bus.busy_mask), 32'h0);

        // 1: ALU only, one-cycle latency, then hold on idle
        bus.alu_valid = 1'b1;
        bus.alu_dest  = 4'd5;
        bus.alu_data  = 32'h0000_1234;
        check("alu_ready_t1", 32'(bus.alu_ready), 32'd1);
        tick();
        bus.alu_valid = 1'b0;
        check_wr("t1_write", 1'b1, 4'd5, 32'h0000_1234);
        tick();
        check_wr("t1_idle_hold", 1'b0, 4'd5, 32'h0000_1234);

        // 2: load only, two-cycle latency
        bus.ld_valid = 1'b1;
        bus.ld_dest  = 4'd3;
        bus.ld_data  = 32'h0000_DEAD;
        tick();
        bus.ld_valid = 1'b0;
        check("t2_after_push_en", 32'(bus.wr_en), 32'd0);
        tick();
        check_wr("t2_load_write", 1'b1, 4'd3, 32'h0000_DEAD);
        check("t2_ld_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        check("t2_drained_en", 32'(bus.wr_en), 32'd0);

        // 3: starvation - one load queued, ALU held valid
        bus.ld_valid  = 1'b1;
        bus.ld_dest   = 4'hA;
        bus.ld_data   = 32'h0000_AAAA;
        bus.alu_valid = 1'b1;
        bus.alu_dest  = 4'd1;
        bus.alu_data  = 32'h0000_0100;
        tick();
        bus.ld_valid = 1'b0;
        check_wr("t3_alu0", 1'b1, 4'd1, 32'h0000_0100);
        bus.alu_data = 32'h0000_0101;
        tick();
        check_wr("t3_alu1", 1'b1, 4'd1, 32'h0000_0101);
        check("t3_alu_ready1", 32'(bus.alu_ready), 32'd1);
        bus.alu_data = 32'h0000_0102;
        tick();
        check_wr("t3_alu2", 1'b1, 4'd1, 32'h0000_0102);
        check("t3_alu_ready2", 32'(bus.alu_ready), 32'd1);
        bus.alu_data = 32'h0000_0103;
        tick();
        check_wr("t3_alu3", 1'b1, 4'd1, 32'h0000_0103);
        check("t3_forced_stall", 32'(bus.alu_ready), 32'd0);
        bus.alu_data = 32'h0000_0104;
        tick();
        check_wr("t3_forced_load", 1'b1, 4'hA, 32'h0000_AAAA);
        check("t3_alu_ready_back", 32'(bus.alu_ready), 32'd1);
        tick();
        check_wr("t3_alu4", 1'b1, 4'd1, 32'h0000_0104);
        bus.alu_valid = 1'b0;
        tick();
        check("t3_idle_en", 32'(bus.wr_en), 32'd0);

        // 4: fill FIFO under continuous ALU traffic, then drain in order
        bus.alu_valid = 1'b1;
        bus.alu_dest  = 4'd2;
        bus.ld_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.ld_dest  = 4'(8 + i);
            bus.ld_data  = 32'hC0DE_0000 + 32'(i);
            bus.alu_data = 32'h0000_0200 + 32'(i);
            check($sformatf("t4_ld_ready_%0d", i), 32'(bus.ld_ready), 32'd1);
            tick();
            check_wr($sformatf("t4_alu_%0d", i), 1'b1, 4'd2, 32'h0000_0200 + 32'(i));
        end
        check("t4_full_ld_ready",  32'(bus.ld_ready),  32'd0);
        check("t4_full_alu_ready", 32'(bus.alu_ready), 32'd0);
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_wr($sformatf("t4_drain_%0d", i), 1'b1, 4'(8 + i), 32'hC0DE_0000 + 32'(i));
        end
        tick();
        check("t4_empty_en", 32'(bus.wr_en), 32'd0);

        // 5: reset with two loads queued
        bus.alu_valid = 1'b1;
        bus.alu_dest  = 4'd6;
        bus.alu_data  = 32'h0000_0600;
        bus.ld_valid  = 1'b1;
        bus.ld_dest   = 4'd12;
        bus.ld_data   = 32'h0000_1212;
        tick();
        bus.alu_data = 32'h0000_0601;
        bus.ld_dest  = 4'd13;
        bus.ld_data  = 32'h0000_1313;
        tick();
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        check_wr("t5_pre_rst", 1'b1, 4'd6, 32'h0000_0601);
        rst_n = 1'b0;
        #1;
        check_wr("t5_in_rst", 1'b0, 4'd0, 32'h0);
        check("t5_in_rst_ld_ready", 32'(bus.ld_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_wr($sformatf("t5_no_stale_%0d", i), 1'b0, 4'd0, 32'h0);
        end
        check("t5_mask", 32'(bus.busy_mask), 32'h0);

        // 6: pending-destination mask
        bus.alu_valid = 1'b1;
        bus.alu_dest  = 4'd1;
        bus.alu_data  = 32'h0000_0700;
        bus.ld_valid  = 1'b1;
        bus.ld_dest   = 4'd7;
        bus.ld_data   = 32'h0000_0777;
        tick();
        bus.ld_dest = 4'd9;
        bus.ld_data = 32'h0000_0999;
        tick();
        bus.ld_valid = 1'b0;
        check("t6_mask_e2", 32'(bus.busy_mask), 32'(mask_e2));
        tick();
        bus.alu_valid = 1'b0;
        check("t6_mask_both", 32'(bus.busy_mask), 32'(mask_e3));
        tick();
        check_wr("t6_ld7", 1'b1, 4'd7, 32'h0000_0777);
        tick();
        check_wr("t6_ld9", 1'b1, 4'd9, 32'h0000_0999);
        check("t6_mask_one", 32'(bus.busy_mask), 32'(mask_e5));
        tick();
        check("t6_mask_clear", 32'(bus.busy_mask), 32'h0);
        check("t6_idle_en", 32'(bus.wr_en), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
